// File: rtl/common_fifo_rdstream_1r_pkg.sv
// Shared constants and the read-credit helper for the FIFO read-stream adapter.
package common_fifo_rdstream_1r_pkg;

   localparam int unsigned BUF_DEPTH   = 2;
   localparam int unsigned BUF_LEVEL_W = 2;
   localparam int unsigned CREDIT_W    = 3;

   // True when a new read still fits once buffered and in-flight words are counted.
   function automatic logic credit_ok(input logic [CREDIT_W-1:0] occ,
                                      input logic                inflight,
                                      input logic                pop);
      logic [CREDIT_W-1:0] pending;
      pending = occ + CREDIT_W'(inflight) - CREDIT_W'(pop);
      return pending <= CREDIT_W'(BUF_DEPTH - 1);
   endfunction

endpackage

// File: rtl/common_fifo_rdstream_buf2.sv
// Two-entry head/tail buffer: captures FIFO read data, shifts tail to head on pop.
module common_fifo_rdstream_buf2
   import common_fifo_rdstream_1r_pkg::*;
#(
   parameter int unsigned            DATA_WIDTH       = 1,
   parameter logic [DATA_WIDTH-1:0]  DATA_RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   pop,
   input  logic [BUF_LEVEL_W-1:0] occ,
   input  logic                   capture,
   input  logic [DATA_WIDTH-1:0]  din,
   output logic [DATA_WIDTH-1:0]  head
);

   logic [BUF_LEVEL_W-1:0] occ_after_pop;
   logic                   shift;
   logic                   cap_head;
   logic                   cap_tail;
   logic                   head_en;
   logic [DATA_WIDTH-1:0]  head_d;
   logic [DATA_WIDTH-1:0]  tail;

   // Flush freezes the data registers; the in-flight word is simply not captured.
   always_comb begin
      occ_after_pop = occ - BUF_LEVEL_W'(pop);
      shift         = pop & (occ == BUF_LEVEL_W'(BUF_DEPTH)) & ~flush;
      cap_head      = capture & ~flush & (occ_after_pop == '0);
      cap_tail      = capture & ~flush & (occ_after_pop != '0);
      head_en       = shift | cap_head;
      head_d        = cap_head ? din : tail;
   end

   stdmacro_dffe #(
      .WIDTH       (DATA_WIDTH),
      .RESET_VALUE (DATA_RESET_VALUE)
   ) u_head (
      .clk   (clk),
      .reset (reset),
      .en    (head_en),
      .d     (head_d),
      .q     (head)
   );

   stdmacro_dffe #(
      .WIDTH       (DATA_WIDTH),
      .RESET_VALUE (DATA_RESET_VALUE)
   ) u_tail (
      .clk   (clk),
      .reset (reset),
      .en    (cap_tail),
      .d     (din),
      .q     (tail)
   );

endmodule

// File: rtl/stdmacro_dffe.sv
// Enabled D flip-flop with synchronous active-high reset.
module stdmacro_dffe #(
   parameter int unsigned       WIDTH       = 1,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= RESET_VALUE;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/common_fifo_rdstream_1r.sv
// Read-side adapter turning a 1-cycle-latency RAM FIFO into a bubble-free valid/ready stream.
module common_fifo_rdstream_1r
   import common_fifo_rdstream_1r_pkg::*;
#(
   parameter int unsigned            DATA_WIDTH       = 1,
   parameter logic [DATA_WIDTH-1:0]  DATA_RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic [DATA_WIDTH-1:0]  fifo_dout,
   input  logic                   fifo_empty,
   output logic                   fifo_ren,
   output logic                   m_valid,
   output logic [DATA_WIDTH-1:0]  m_data,
   input  logic                   m_ready,
   output logic [BUF_LEVEL_W-1:0] buf_level
);

   logic [BUF_LEVEL_W-1:0] occ;
   logic [BUF_LEVEL_W-1:0] occ_d;
   logic [CREDIT_W-1:0]    occ_next;
   logic                   inflight;
   logic                   pop;

   always_comb begin
      m_valid   = (occ != '0);
      pop       = m_valid & m_ready;
      buf_level = occ;
      fifo_ren  = ~reset & ~flush & ~fifo_empty & credit_ok(CREDIT_W'(occ), inflight, pop);
      occ_next  = CREDIT_W'(occ) - CREDIT_W'(pop) + CREDIT_W'(inflight);
      occ_d     = flush ? '0 : BUF_LEVEL_W'(occ_next);
   end

   stdmacro_dffe #(
      .WIDTH       (BUF_LEVEL_W),
      .RESET_VALUE ('0)
   ) u_occ (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .d     (occ_d),
      .q     (occ)
   );

   // fifo_ren is already low during flush, so the flush also clears inflight.
   stdmacro_dffe #(
      .WIDTH       (1),
      .RESET_VALUE (1'b0)
   ) u_inflight (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .d     (fifo_ren),
      .q     (inflight)
   );

   common_fifo_rdstream_buf2 #(
      .DATA_WIDTH       (DATA_WIDTH),
      .DATA_RESET_VALUE (DATA_RESET_VALUE)
   ) u_buf (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .pop     (pop),
      .occ     (occ),
      .capture (inflight),
      .din     (fifo_dout),
      .head    (m_data)
   );

   a_occ_bound: assert property (@(posedge clk) disable iff (reset)
      occ_next <= CREDIT_W'(BUF_DEPTH));

endmodule

// File: tb/tb_common_fifo_rdstream_1r.sv
// Directed bench for the FIFO read-stream adapter with a small RAM-FIFO model.
module tb_common_fifo_rdstream_1r;

   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic [DW-1:0] fifo_dout = '0;
   logic          fifo_empty;
   logic          fifo_ren;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready;
   logic [1:0]    buf_level;

   logic          push;
   logic [DW-1:0] push_data;
   logic [DW-1:0] mem [0:63];
   int unsigned   wptr = 0;
   int unsigned   rptr = 0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   common_fifo_rdstream_1r #(
      .DATA_WIDTH       (DW),
      .DATA_RESET_VALUE (8'h00)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .fifo_dout  (fifo_dout),
      .fifo_empty (fifo_empty),
      .fifo_ren   (fifo_ren),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_ready    (m_ready),
      .buf_level  (buf_level)
   );

   // RAM FIFO model: registered dout, empty flag follows the pointers.
   always @(posedge clk) begin
      if (push) begin
         mem[wptr[5:0]] <= push_data;
         wptr <= wptr + 1;
      end
      if (fifo_ren) begin
         fifo_dout <= mem[rptr[5:0]];
         rptr <= rptr + 1;
      end
   end
   assign fifo_empty = (wptr == rptr);

   typedef struct {
      logic          rst;
      logic          fl;
      logic          rdy;
      logic          psh;
      logic [DW-1:0] pd;
      logic          ev;
      logic [DW-1:0] ed;
      logic [1:0]    el;
      logic          er;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic fl, input logic rdy, input logic psh,
                      input logic [DW-1:0] pd, input logic ev, input logic [DW-1:0] ed,
                      input logic [1:0] el, input logic er);
      vec_t v;
      v = '{rst, fl, rdy, psh, pd, ev, ed, el, er};
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic invariants(input string tag);
      chk({tag, "_ren_while_empty"}, {31'd0, fifo_ren & fifo_empty}, 32'd0);
      chk({tag, "_level_max"}, {31'd0, buf_level <= 2'd2}, 32'd1);
   endtask

   task automatic preload(input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         reset = 1'b1;
         flush = 1'b0;
         m_ready = 1'b0;
         push = 1'b1;
         push_data = base + DW'(i);
      end
      @(negedge clk);
      push = 1'b0;
      reset = 1'b0;
   endtask

   initial begin
      int got;
      int nren;
      int first_ren;
      int last_ren;
      int first_beat;
      logic prev_stall;
      logic [DW-1:0] prev_data;

      reset = 1'b1;
      flush = 1'b0;
      m_ready = 1'b0;
      push = 1'b0;
      push_data = '0;

      //   rst fl rdy psh pd      ev ed      el    er
      add(1, 0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 0);  // reset state
      add(0, 0, 0, 1, 8'h11, 0, 8'h00, 2'd0, 0);  // empty start
      add(0, 0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 1);
      add(0, 0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 0);
      add(0, 0, 0, 0, 8'h00, 1, 8'h11, 2'd1, 0);
      add(0, 0, 1, 0, 8'h00, 1, 8'h11, 2'd1, 0);
      add(0, 0, 0, 0, 8'h00, 0, 8'h11, 2'd0, 0);
      add(0, 0, 0, 1, 8'h21, 0, 8'h11, 2'd0, 0);  // backpressure
      add(0, 0, 0, 1, 8'h22, 0, 8'h11, 2'd0, 1);
      add(0, 0, 0, 1, 8'h23, 0, 8'h11, 2'd0, 1);
      add(0, 0, 0, 1, 8'h24, 1, 8'h21, 2'd1, 0);
      add(0, 0, 0, 0, 8'h00, 1, 8'h21, 2'd2, 0);
      add(0, 0, 0, 0, 8'h00, 1, 8'h21, 2'd2, 0);
      add(0, 0, 1, 0, 8'h00, 1, 8'h21, 2'd2, 1);
      add(0, 0, 1, 0, 8'h00, 1, 8'h22, 2'd1, 1);
      add(0, 0, 1, 0, 8'h00, 1, 8'h23, 2'd1, 0);
      add(0, 0, 1, 0, 8'h00, 1, 8'h24, 2'd1, 0);
      add(0, 0, 0, 0, 8'h00, 0, 8'h24, 2'd0, 0);
      add(0, 0, 0, 1, 8'hA1, 0, 8'h24, 2'd0, 0);  // reset mid-stream
      add(0, 0, 0, 1, 8'hB2, 0, 8'h24, 2'd0, 1);
      add(0, 0, 0, 1, 8'hC3, 0, 8'h24, 2'd0, 1);
      add(0, 0, 0, 0, 8'h00, 1, 8'hA1, 2'd1, 0);
      add(1, 0, 0, 0, 8'h00, 1, 8'hA1, 2'd2, 0);
      add(0, 0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 1);
      add(0, 0, 0, 0, 8'h00, 0, 8'h00, 2'd0, 0);
      add(0, 0, 1, 0, 8'h00, 1, 8'hC3, 2'd1, 0);
      add(0, 0, 0, 1, 8'h31, 0, 8'hC3, 2'd0, 0);  // flush with occ=1, inflight=1
      add(0, 0, 0, 1, 8'h32, 0, 8'hC3, 2'd0, 1);
      add(0, 0, 0, 1, 8'h33, 0, 8'hC3, 2'd0, 1);
      add(0, 1, 1, 0, 8'h00, 1, 8'h31, 2'd1, 0);
      add(0, 0, 0, 0, 8'h00, 0, 8'h31, 2'd0, 1);
      add(0, 0, 0, 0, 8'h00, 0, 8'h31, 2'd0, 0);
      add(0, 0, 1, 0, 8'h00, 1, 8'h33, 2'd1, 0);
      add(0, 0, 0, 0, 8'h00, 0, 8'h33, 2'd0, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         reset = vecs[i].rst;
         flush = vecs[i].fl;
         m_ready = vecs[i].rdy;
         push = vecs[i].psh;
         push_data = vecs[i].pd;
         #1;
         chk($sformatf("v%0d_m_valid", i), {31'd0, m_valid}, {31'd0, vecs[i].ev});
         chk($sformatf("v%0d_m_data", i), {24'd0, m_data}, {24'd0, vecs[i].ed});
         chk($sformatf("v%0d_buf_level", i), {30'd0, buf_level}, {30'd0, vecs[i].el});
         chk($sformatf("v%0d_fifo_ren", i), {31'd0, fifo_ren}, {31'd0, vecs[i].er});
      end

      // Streaming: eight preloaded words with m_ready held high.
      preload(8, 8'h01);
      m_ready = 1'b1;
      got = 0;
      nren = 0;
      first_ren = -1;
      last_ren = -1;
      first_beat = -1;
      for (int c = 0; c < 20; c++) begin
         #1;
         invariants("stream");
         if (fifo_ren) begin
            if (first_ren < 0) first_ren = c;
            last_ren = c;
            nren++;
         end
         if (m_valid && m_ready) begin
            if (first_beat < 0) first_beat = c;
            chk("stream_data", {24'd0, m_data}, {24'd0, DW'(got + 1)});
            chk("stream_no_bubble", c, first_beat + got);
            got++;
         end
         @(negedge clk);
      end
      chk("stream_beats", got, 8);
      chk("stream_ren_count", nren, 8);
      chk("stream_ren_contiguous", last_ren - first_ren, 7);
      chk("stream_first_beat_latency", first_beat - first_ren, 2);

      // Alternating m_ready against a 16-word FIFO.
      preload(16, 8'h40);
      got = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      for (int c = 0; c < 100; c++) begin
         if (got == 16) break;
         m_ready = (c % 2 == 0);
         #1;
         invariants("alt");
         if (prev_stall) begin
            chk("alt_hold_valid", {31'd0, m_valid}, 32'd1);
            chk("alt_hold_data", {24'd0, m_data}, {24'd0, prev_data});
         end
         if (m_valid && m_ready) begin
            chk("alt_order", {24'd0, m_data}, {24'd0, 8'h40 + DW'(got)});
            got++;
         end
         prev_stall = m_valid & ~m_ready;
         prev_data = m_data;
         @(negedge clk);
      end
      chk("alt_beats", got, 16);
      m_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
